// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory access arbiter: exception codes, FSM
// states, requester ids and the latched access record.
package mem_arb_pkg;

  localparam logic [2:0] EXC_NONE   = 3'b000;
  localparam logic [2:0] EXC_ADEL   = 3'b001;
  localparam logic [2:0] EXC_ADES   = 3'b010;
  localparam logic [2:0] EXC_TLBL   = 3'b011;
  localparam logic [2:0] EXC_TLBS   = 3'b100;
  localparam logic [2:0] EXC_BUSERR = 3'b101;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_DM = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_XLAT,
    ST_TLB_WAIT,
    ST_BUS,
    ST_RESP
  } arb_state_e;

  typedef struct packed {
    logic        id;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_req_t;

  // Fetches must be word aligned; data accesses must match their byte enables.
  function automatic logic acc_misaligned(acc_req_t r);
    logic two_byte;
    two_byte = ($countones(r.be) == 2);
    if (r.id == REQ_IF) return r.addr[1:0] != 2'b00;
    return ((r.be == 4'hF) && (r.addr[1:0] != 2'b00)) || (two_byte && r.addr[0]);
  endfunction

  function automatic logic [2:0] addr_excp(logic we);
    return we ? EXC_ADES : EXC_ADEL;
  endfunction

  function automatic logic [2:0] tlb_excp(logic we);
    return we ? EXC_TLBS : EXC_TLBL;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection: DM has priority, but a pending IF that has lost
// STARVE_LIMIT consecutive arbitrations is forced through.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic if_req,
  input  logic dm_req,
  output logic grant,
  output logic grant_id
);

  localparam int CW = $clog2(STARVE_LIMIT + 2);

  logic [CW-1:0] starve_cnt;
  logic          if_forced;

  assign if_forced = if_req && (starve_cnt >= CW'(STARVE_LIMIT));

  always_comb begin
    grant    = arb_en && (if_req || dm_req);
    grant_id = (dm_req && !if_forced) ? REQ_DM : REQ_IF;
  end

  // Counts DM wins over a waiting IF; saturates at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant) begin
      if (grant_id == REQ_IF)
        starve_cnt <= '0;
      else if (if_req && (starve_cnt < CW'(STARVE_LIMIT)))
        starve_cnt <= starve_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Sequences IF/DM accesses through segment mapper, TLB and the external bus.
// Optional bus/TLB watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT   = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        user_mode_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_ack_o,
  output logic [31:0] if_rdata_o,
  output logic [2:0]  if_excp_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [3:0]  dm_be_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic        dm_ack_o,
  output logic [31:0] dm_rdata_o,
  output logic [2:0]  dm_excp_o,
  output logic        map_enable_o,
  output logic [31:0] map_addr_o,
  input  logic [31:0] map_paddr_i,
  input  logic        map_invalid_i,
  input  logic        map_using_tlb_i,
  input  logic        map_uncached_i,
  output logic        tlb_req_o,
  output logic [31:0] tlb_vaddr_o,
  input  logic        tlb_ack_i,
  input  logic        tlb_miss_i,
  input  logic [31:0] tlb_paddr_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic        bus_uncached_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        busy_o
);

  arb_state_e  state, state_nxt;
  acc_req_t    acc_q;
  logic [31:0] paddr_q;
  logic        unc_q;
  logic [31:0] rdata_q;
  logic [2:0]  excp_q;
  logic        grant, grant_id;
  logic        xlat_fault;
  logic        wdog_hit;

  // The user_mode_i input is consumed by the external mapper via map_invalid_i.
  logic unused_user_mode;
  assign unused_user_mode = user_mode_i;

  mem_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
    .clk      (clk),
    .rst      (rst),
    .arb_en   (state == ST_IDLE),
    .if_req   (if_req_i),
    .dm_req   (dm_req_i),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign xlat_fault = acc_misaligned(acc_q) || map_invalid_i;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [7:0] wdog_q;

  // Restarts on every state change, so each wait state gets a full budget.
  always_ff @(posedge clk) begin
    if (rst || (state_nxt != state))
      wdog_q <= '0;
    else if ((state == ST_TLB_WAIT) || (state == ST_BUS))
      wdog_q <= wdog_q + 8'd1;
  end

  assign wdog_hit = (wdog_q == 8'(TIMEOUT_CYCLES - 1));
`else
  // No watchdog: waits are unbounded; parameter only kept in the interface.
  assign wdog_hit = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (grant) state_nxt = ST_XLAT;
      ST_XLAT: begin
        if (xlat_fault)           state_nxt = ST_RESP;
        else if (map_using_tlb_i) state_nxt = ST_TLB_WAIT;
        else                      state_nxt = ST_BUS;
      end
      ST_TLB_WAIT: begin
        if (tlb_miss_i)     state_nxt = ST_RESP;
        else if (tlb_ack_i) state_nxt = ST_BUS;
        else if (wdog_hit)  state_nxt = ST_RESP;
      end
      ST_BUS:      if (bus_ack_i || wdog_hit) state_nxt = ST_RESP;
      ST_RESP:     state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      acc_q   <= '0;
      paddr_q <= '0;
      unc_q   <= 1'b0;
      rdata_q <= '0;
      excp_q  <= EXC_NONE;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: if (grant) begin
          // IF is a plain word read; store fields only come from DM.
          acc_q.id    <= grant_id;
          acc_q.addr  <= (grant_id == REQ_DM) ? dm_addr_i : if_addr_i;
          acc_q.we    <= (grant_id == REQ_DM) ? dm_we_i : 1'b0;
          acc_q.be    <= (grant_id == REQ_DM) ? dm_be_i : 4'hF;
          acc_q.wdata <= (grant_id == REQ_DM) ? dm_wdata_i : 32'h0;
          rdata_q     <= '0;
          excp_q      <= EXC_NONE;
        end
        ST_XLAT: begin
          if (xlat_fault) begin
            excp_q <= addr_excp(acc_q.we);
          end else if (!map_using_tlb_i) begin
            paddr_q <= map_paddr_i;
            unc_q   <= map_uncached_i;
          end
        end
        ST_TLB_WAIT: begin
          if (tlb_miss_i) begin
            excp_q <= tlb_excp(acc_q.we);
          end else if (tlb_ack_i) begin
            paddr_q <= tlb_paddr_i;
            unc_q   <= 1'b0;
          end else if (wdog_hit) begin
            excp_q <= EXC_BUSERR;
          end
        end
        ST_BUS: begin
          if (bus_ack_i)     rdata_q <= bus_rdata_i;
          else if (wdog_hit) excp_q  <= EXC_BUSERR;
        end
        default: ;
      endcase
    end
  end

  // Outputs are state-gated so everything reads zero in IDLE and after reset.
  always_comb begin
    busy_o         = (state != ST_IDLE);
    map_enable_o   = (state == ST_XLAT);
    map_addr_o     = map_enable_o ? acc_q.addr : 32'h0;
    tlb_req_o      = (state == ST_TLB_WAIT);
    tlb_vaddr_o    = tlb_req_o ? acc_q.addr : 32'h0;
    bus_req_o      = (state == ST_BUS);
    bus_we_o       = bus_req_o && acc_q.we;
    bus_be_o       = bus_req_o ? acc_q.be : 4'h0;
    bus_addr_o     = bus_req_o ? paddr_q : 32'h0;
    bus_wdata_o    = bus_req_o ? acc_q.wdata : 32'h0;
    bus_uncached_o = bus_req_o && unc_q;
    if_ack_o       = (state == ST_RESP) && (acc_q.id == REQ_IF);
    dm_ack_o       = (state == ST_RESP) && (acc_q.id == REQ_DM);
    if_rdata_o     = if_ack_o ? rdata_q : 32'h0;
    if_excp_o      = if_ack_o ? excp_q : EXC_NONE;
    dm_rdata_o     = dm_ack_o ? rdata_q : 32'h0;
    dm_excp_o      = dm_ack_o ? excp_q : EXC_NONE;
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Randomized scoreboard bench for mem_access_arbiter with mapper/TLB/bus
// environment models; timeout phase runs when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_access_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        user_mode_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_ack_o;
  logic [31:0] if_rdata_o;
  logic [2:0]  if_excp_o;
  logic        dm_req_i, dm_we_i;
  logic [3:0]  dm_be_i;
  logic [31:0] dm_addr_i, dm_wdata_i;
  logic        dm_ack_o;
  logic [31:0] dm_rdata_o;
  logic [2:0]  dm_excp_o;
  logic        map_enable_o;
  logic [31:0] map_addr_o, map_paddr_i;
  logic        map_invalid_i, map_using_tlb_i, map_uncached_i;
  logic        tlb_req_o;
  logic [31:0] tlb_vaddr_o, tlb_paddr_i;
  logic        tlb_ack_i, tlb_miss_i;
  logic        bus_req_o, bus_we_o, bus_uncached_o, bus_ack_i;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic        busy_o;

  always #5 clk = ~clk;

  mem_access_arbiter dut (
    .clk(clk), .rst(rst), .user_mode_i(user_mode_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o),
    .if_rdata_o(if_rdata_o), .if_excp_o(if_excp_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_be_i(dm_be_i),
    .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i), .dm_ack_o(dm_ack_o),
    .dm_rdata_o(dm_rdata_o), .dm_excp_o(dm_excp_o),
    .map_enable_o(map_enable_o), .map_addr_o(map_addr_o), .map_paddr_i(map_paddr_i),
    .map_invalid_i(map_invalid_i), .map_using_tlb_i(map_using_tlb_i),
    .map_uncached_i(map_uncached_i),
    .tlb_req_o(tlb_req_o), .tlb_vaddr_o(tlb_vaddr_o), .tlb_ack_i(tlb_ack_i),
    .tlb_miss_i(tlb_miss_i), .tlb_paddr_i(tlb_paddr_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_be_o(bus_be_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_uncached_o(bus_uncached_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i), .busy_o(busy_o)
  );

  typedef struct packed { logic [2:0] excp; logic [31:0] rdata; } resp_t;

  int    checks = 0, failures = 0;
  resp_t if_q[$], dm_q[$];
  string order = "";
  int    bus_lo = 0, bus_hi = 2, tlb_lo = 0, tlb_hi = 3;
  bit    bus_hang = 0;
  int    bus_cycles = 0, tlb_cycles = 0;
  logic [31:0] last_bus_addr = '0;
  logic        last_bus_unc = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---- environment: segment mapper, TLB contents, bus data pattern ----
  always_comb begin
    map_paddr_i     = map_addr_o & 32'h1FFF_FFFF;
    map_invalid_i   = user_mode_i && map_addr_o[31];
    map_using_tlb_i = !map_addr_o[31] || (map_addr_o[31:30] == 2'b11);
    map_uncached_i  = (map_addr_o[31:29] == 3'b101);
  end

  function automatic logic [31:0] tlb_pa(logic [31:0] va);
    return {va[31:12] ^ 20'h5A5A5, va[11:0]};
  endfunction

  function automatic logic [31:0] bus_fn(logic [31:0] pa, logic unc, logic we,
                                         logic [3:0] be, logic [31:0] wd);
    return (pa * 32'h9E37_79B1) ^ {unc, we, be, 26'h0} ^ (we ? wd : 32'h0);
  endfunction

  // ---- reference model: outcome of one access from its request alone ----
  function automatic resp_t model(bit is_if, bit we, logic [3:0] be, logic [31:0] va,
                                  logic [31:0] wd, bit user, bit hang);
    resp_t r;
    logic [31:0] pa;
    bit unc, bad_align;
    r = '0;
    if (is_if) bad_align = (va[1:0] != 0);
    else bad_align = (be == 4'hF && va[1:0] != 0) || ($countones(be) == 2 && va[0]);
    if (bad_align || (user && va[31])) begin
      r.excp = we ? 3'd2 : 3'd1;
      return r;
    end
    if (va >= 32'h8000_0000 && va < 32'hC000_0000) begin
      pa  = va - (va >= 32'hA000_0000 ? 32'hA000_0000 : 32'h8000_0000);
      unc = (va >= 32'hA000_0000);
    end else begin
      if (va[22]) begin
        r.excp = we ? 3'd4 : 3'd3;
        return r;
      end
      pa  = tlb_pa(va);
      unc = 0;
    end
    if (hang) begin
      r.excp = 3'd5;
      return r;
    end
    r.rdata = bus_fn(pa, unc, we, be, wd);
    return r;
  endfunction

  // ---- bus responder ----
  initial begin : bus_resp
    int cnt, dly;
    cnt = 0; dly = 0;
    bus_ack_i = 0; bus_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (bus_req_o) bus_cycles++;
      if (bus_ack_i) begin
        bus_ack_i = 0; bus_rdata_i = '0;
      end else if (!bus_req_o) begin
        cnt = 0;
      end else begin
        if (cnt == 0) dly = $urandom_range(bus_hi, bus_lo);
        if (!bus_hang && cnt >= dly) begin
          bus_ack_i     = 1;
          bus_rdata_i   = bus_fn(bus_addr_o, bus_uncached_o, bus_we_o, bus_be_o, bus_wdata_o);
          last_bus_addr = bus_addr_o;
          last_bus_unc  = bus_uncached_o;
        end
        cnt++;
      end
    end
  end

  // ---- TLB responder; on a miss it sometimes also raises ack ----
  initial begin : tlb_resp
    int cnt, dly;
    cnt = 0; dly = 0;
    tlb_ack_i = 0; tlb_miss_i = 0; tlb_paddr_i = '0;
    forever begin
      @(negedge clk);
      if (tlb_req_o) tlb_cycles++;
      if (tlb_ack_i || tlb_miss_i) begin
        tlb_ack_i = 0; tlb_miss_i = 0;
      end else if (!tlb_req_o) begin
        cnt = 0;
      end else begin
        if (cnt == 0) dly = $urandom_range(tlb_hi, tlb_lo);
        if (cnt >= dly) begin
          tlb_paddr_i = tlb_pa(tlb_vaddr_o);
          tlb_miss_i  = tlb_vaddr_o[22];
          tlb_ack_i   = tlb_vaddr_o[22] ? 1'($urandom_range(1, 0)) : 1'b1;
        end
        cnt++;
      end
    end
  end

  // ---- monitor / scoreboard ----
  initial begin : monitor
    resp_t e;
    forever begin
      @(negedge clk);
      if (if_ack_o && dm_ack_o) begin
        checks++; failures++;
        $display("FAIL dual_ack if_ack=%b dm_ack=%b required one-hot", if_ack_o, dm_ack_o);
      end
      if (if_ack_o) begin
        order = {order, "I"};
        if (if_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_if_ack rdata=%h required no ack", if_rdata_o);
        end else begin
          e = if_q.pop_front();
          chk("if_excp", 32'(if_excp_o), 32'(e.excp));
          chk("if_rdata", if_rdata_o, e.rdata);
        end
      end
      if (dm_ack_o) begin
        order = {order, "D"};
        if (dm_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_dm_ack rdata=%h required no ack", dm_rdata_o);
        end else begin
          e = dm_q.pop_front();
          chk("dm_excp", 32'(dm_excp_o), 32'(e.excp));
          chk("dm_rdata", dm_rdata_o, e.rdata);
        end
      end
    end
  end

  // ---- requester tasks ----
  task automatic wait_ack(bit is_if, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(is_if ? if_ack_o : dm_ack_o) && cyc < 2000);
    if (cyc >= 2000) begin
      checks++; failures++;
      $display("FAIL ack_timeout %s no ack after %0d cycles", is_if ? "if" : "dm", cyc);
    end
  endtask

  task automatic issue_if(logic [31:0] a, bit hang, output int cyc);
    if_addr_i = a;
    if_req_i  = 1;
    if_q.push_back(model(1, 0, 4'hF, a, 32'h0, user_mode_i, hang));
    wait_ack(1, cyc);
  endtask

  task automatic issue_dm(bit we, logic [3:0] be, logic [31:0] a, logic [31:0] wd,
                          bit hang, output int cyc);
    dm_we_i = we; dm_be_i = be; dm_addr_i = a; dm_wdata_i = wd;
    dm_req_i = 1;
    dm_q.push_back(model(0, we, be, a, wd, user_mode_i, hang));
    wait_ack(0, cyc);
  endtask

  function automatic logic [31:0] rand_addr(logic [3:0] be);
    logic [31:0] r;
    int seg;
    r   = $urandom();
    seg = $urandom_range(3, 0);
    case (seg)
      0:       r = r & 32'h7FFF_FFFF;
      1:       r = 32'h8000_0000 | (r & 32'h1FFF_FFFF);
      2:       r = 32'hA000_0000 | (r & 32'h1FFF_FFFF);
      default: r = 32'hC000_0000 | (r & 32'h3FFF_FFFF);
    endcase
    if ($urandom_range(4, 0) != 0) begin
      if (be == 4'hF) r[1:0] = 2'b00;
      else if ($countones(be) == 2) r[0] = 1'b0;
    end
    return r;
  endfunction

  task automatic run_if(int n, int gap_max);
    int cyc;
    for (int i = 0; i < n; i++) begin
      issue_if(rand_addr(4'hF), 0, cyc);
      if (gap_max > 0 && $urandom_range(1, 0) == 1) begin
        if_req_i = 0;
        repeat ($urandom_range(gap_max, 1)) @(negedge clk);
      end
    end
    if_req_i = 0;
  endtask

  task automatic run_dm(int n, int gap_max);
    logic [3:0] bes[7] = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};
    logic [3:0] be;
    int cyc;
    for (int i = 0; i < n; i++) begin
      be = bes[$urandom_range(6, 0)];
      issue_dm(1'($urandom_range(1, 0)), be, rand_addr(be), $urandom(), 0, cyc);
      if (gap_max > 0 && $urandom_range(1, 0) == 1) begin
        dm_req_i = 0;
        repeat ($urandom_range(gap_max, 1)) @(negedge clk);
      end
    end
    dm_req_i = 0;
  endtask

  // ---- main sequence ----
  initial begin : main
    int cyc, bc, tc, k;
    string exp_order;
    rst = 1; user_mode_i = 0;
    if_req_i = 0; if_addr_i = '0;
    dm_req_i = 0; dm_we_i = 0; dm_be_i = '0; dm_addr_i = '0; dm_wdata_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_bus_req", 32'(bus_req_o), 0);
    chk("rst_acks", {30'h0, if_ack_o, dm_ack_o}, 0);
    chk("rst_map_tlb", {30'h0, map_enable_o, tlb_req_o}, 0);
    chk("rst_bus_addr", bus_addr_o, 0);
    rst = 0;
    @(negedge clk);

    // unmapped fetch, same-cycle bus ack
    bus_lo = 0; bus_hi = 0;
    issue_if(32'h8000_0100, 0, cyc);
    if_req_i = 0;
    chk("if_latency", 32'(cyc), 3);
    chk("if_bus_addr", last_bus_addr, 32'h0000_0100);
    chk("if_bus_unc", 32'(last_bus_unc), 0);

    // both requesters held continuously
    bus_hi = 2;
    order = "";
    fork
      run_if(3, 0);
      run_dm(6, 0);
    join
    @(negedge clk);
    exp_order = "DDIDDIDDI";
    chk("order_len", 32'(order.len()), 32'(exp_order.len()));
    for (int i = 0; i < exp_order.len() && i < order.len(); i++)
      chk($sformatf("grant_order%0d", i), 32'(order[i]), 32'(exp_order[i]));

    // store TLB miss: no bus traffic
    tlb_lo = 2; tlb_hi = 2;
    bc = bus_cycles;
    issue_dm(1, 4'hF, 32'h0040_0000, 32'hCAFE_F00D, 0, cyc);
    dm_req_i = 0;
    chk("tlbs_no_bus", 32'(bus_cycles), 32'(bc));
    tlb_lo = 0; tlb_hi = 3;

    // user-mode kernel access and misaligned fetch
    user_mode_i = 1;
    bc = bus_cycles; tc = tlb_cycles;
    issue_dm(0, 4'hF, 32'h8000_0000, 32'h0, 0, cyc);
    dm_req_i = 0;
    chk("adel_no_bus", 32'(bus_cycles), 32'(bc));
    chk("adel_no_tlb", 32'(tlb_cycles), 32'(tc));
    issue_if(32'h8000_0002, 0, cyc);
    if_req_i = 0;
    user_mode_i = 0;

    // randomized concurrent traffic
    for (int r = 0; r < 6; r++) begin
      user_mode_i = 1'($urandom_range(1, 0));
      bus_hi = $urandom_range(4, 0);
      fork
        run_if(15, 3);
        run_dm(15, 3);
      join
      @(negedge clk);
    end
    user_mode_i = 0;
    chk("rand_if_q_empty", 32'(if_q.size()), 0);
    chk("rand_dm_q_empty", 32'(dm_q.size()), 0);

    // reset while the bus is outstanding
    bus_hang = 1;
    dm_we_i = 0; dm_be_i = 4'hF; dm_addr_i = 32'hA000_0010; dm_wdata_i = '0;
    dm_req_i = 1;
    dm_q.push_back(model(0, 0, 4'hF, 32'hA000_0010, 32'h0, 0, 0));
    k = 0;
    do begin @(negedge clk); k++; end while (!bus_req_o && k < 20);
    chk("kseg1_bus_addr", bus_addr_o, 32'h0000_0010);
    chk("kseg1_bus_unc", 32'(bus_uncached_o), 1);
    rst = 1; dm_req_i = 0;
    @(negedge clk);
    chk("rst_mid_bus_req", 32'(bus_req_o), 0);
    chk("rst_mid_busy", 32'(busy_o), 0);
    rst = 0;
    dm_q.delete();
    bus_hang = 0;
    repeat (6) @(negedge clk);

`ifdef MEM_ARB_TIMEOUT_EN
    bus_hang = 1;
    bc = bus_cycles;
    issue_dm(0, 4'hF, 32'h8000_0040, 32'h0, 1, cyc);
    dm_req_i = 0;
    chk("timeout_bus_cycles", 32'(bus_cycles - bc), 255);
    bus_hang = 0;
    repeat (4) @(negedge clk);
`endif

    repeat (4) @(negedge clk);
    chk("final_if_q_empty", 32'(if_q.size()), 0);
    chk("final_dm_q_empty", 32'(dm_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
